// File: rtl/regfile_seq.sv
// Three-operand sequencer driving a register file's read selects and write port.
// One instruction at a time: IDLE -> READ -> EXEC -> WRITE, four cycles each.
module regfile_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IVALID,
  output logic             IREADY,
  input  logic [2:0]       OP,
  input  logic [2:0]       DREG,
  input  logic [2:0]       AREG,
  input  logic [2:0]       BREG,
  input  logic [WIDTH-1:0] IMM,
  output logic [2:0]       ASEL,
  output logic [2:0]       BSEL,
  output logic [2:0]       DSEL,
  output logic [WIDTH-1:0] RIN,
  output logic [WIDTH-1:0] DIN,
  input  logic [WIDTH-1:0] ABUS,
  input  logic [WIDTH-1:0] BBUS,
  output logic             DONE,
  output logic             ZERO,
  output logic             CARRY
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_MOVI = 3'd6;
  localparam logic [2:0] OP_SHL1 = 3'd7;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d, dreg_q, dreg_d, areg_q, areg_d, breg_q, breg_d;
  logic [WIDTH-1:0] imm_q, imm_d, oa_q, oa_d, ob_q, ob_d, res_q, res_d;
  logic             zero_q, zero_d, carry_q, carry_d;
  logic [WIDTH:0]   sum, diff;

  assign sum  = {1'b0, oa_q} + {1'b0, ob_q};
  assign diff = {1'b0, oa_q} - {1'b0, ob_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dreg_d  = dreg_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    imm_d   = imm_q;
    oa_d    = oa_q;
    ob_d    = ob_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: if (IVALID) begin
        op_d    = OP;
        dreg_d  = DREG;
        areg_d  = AREG;
        breg_d  = BREG;
        imm_d   = IMM;
        state_d = S_READ;
      end
      S_READ: begin
        oa_d    = ABUS;
        ob_d    = BBUS;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD:  begin res_d = sum[WIDTH-1:0];  carry_d = sum[WIDTH];  end
          OP_SUB:  begin res_d = diff[WIDTH-1:0]; carry_d = diff[WIDTH]; end
          OP_AND:  res_d = oa_q & ob_q;
          OP_OR:   res_d = oa_q | ob_q;
          OP_XOR:  res_d = oa_q ^ ob_q;
          OP_MOVI: res_d = oa_q;
          OP_SHL1: begin res_d = {oa_q[WIDTH-2:0], 1'b0}; carry_d = oa_q[WIDTH-1]; end
          default: res_d = '0;
        endcase
        // NOP produces 0 but must not disturb the flags of the previous result
        if (op_q != OP_NOP) zero_d = (res_d == '0);
        state_d = S_WRITE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dreg_q  <= '0;
      areg_q  <= '0;
      breg_q  <= '0;
      imm_q   <= '0;
      oa_q    <= '0;
      ob_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dreg_q  <= dreg_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      imm_q   <= imm_d;
      oa_q    <= oa_d;
      ob_q    <= ob_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // Selects come straight from the latched fields, so they hold between
  // instructions; DSEL is decoded from state so reset kills it at once.
  assign IREADY = (state_q == S_IDLE);
  assign ASEL   = areg_q;
  assign BSEL   = breg_q;
  assign DIN    = imm_q;
  assign DSEL   = (state_q == S_WRITE && op_q != OP_NOP) ? dreg_q : 3'd0;
  assign RIN    = res_q;
  assign DONE   = (state_q == S_WRITE);
  assign ZERO   = zero_q;
  assign CARRY  = carry_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural register file attached.
module tb_regfile_seq;
  logic        CLK = 1'b0, RST = 1'b0, IVALID = 1'b0;
  logic        IREADY, DONE, ZERO, CARRY;
  logic [2:0]  OP = '0, DREG = '0, AREG = '0, BREG = '0;
  logic [2:0]  ASEL, BSEL, DSEL;
  logic [15:0] IMM = '0, RIN, DIN, ABUS, BBUS;
  logic [15:0] rf [0:7];
  int          checks = 0, errors = 0;

  regfile_seq #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .IVALID(IVALID), .IREADY(IREADY),
    .OP(OP), .DREG(DREG), .AREG(AREG), .BREG(BREG), .IMM(IMM),
    .ASEL(ASEL), .BSEL(BSEL), .DSEL(DSEL), .RIN(RIN), .DIN(DIN),
    .ABUS(ABUS), .BBUS(BBUS), .DONE(DONE), .ZERO(ZERO), .CARRY(CARRY)
  );

  always #5 CLK = ~CLK;

  assign ABUS = (ASEL == 3'd0) ? DIN : rf[ASEL];
  assign BBUS = (BSEL == 3'd0) ? DIN : rf[BSEL];
  always @(posedge CLK) if (DSEL != 3'd0) rf[DSEL] <= RIN;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_irdy"}, IREADY, 1);
    chk({tag, "_asel"}, ASEL, 0);
    chk({tag, "_bsel"}, BSEL, 0);
    chk({tag, "_dsel"}, DSEL, 0);
    chk({tag, "_rin"}, RIN, 0);
    chk({tag, "_din"}, DIN, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_zero"}, ZERO, 0);
    chk({tag, "_carry"}, CARRY, 0);
  endtask

  // Issue one instruction and check every cycle of its 4-cycle sequence.
  task automatic run(input string tag, input logic [2:0] op, d, a, b, input logic [15:0] imm,
                     input logic [2:0] exp_dsel, input logic [15:0] exp_rin,
                     input logic exp_z, exp_c, input logic pulse);
    @(negedge CLK);
    chk({tag, "_rdy0"}, IREADY, 1);
    OP = op; DREG = d; AREG = a; BREG = b; IMM = imm; IVALID = 1'b1;
    @(posedge CLK); #1;
    IVALID = 1'b0; OP = ~op; DREG = ~d; AREG = ~a; BREG = ~b; IMM = ~imm;
    @(negedge CLK);
    chk({tag, "_rdy1"}, IREADY, 0);
    chk({tag, "_asel"}, ASEL, a);
    chk({tag, "_bsel"}, BSEL, b);
    chk({tag, "_din"}, DIN, imm);
    chk({tag, "_dsel1"}, DSEL, 0);
    chk({tag, "_done1"}, DONE, 0);
    if (pulse) IVALID = 1'b1;
    @(negedge CLK);
    chk({tag, "_rdy2"}, IREADY, 0);
    chk({tag, "_dsel2"}, DSEL, 0);
    chk({tag, "_done2"}, DONE, 0);
    @(negedge CLK);
    IVALID = 1'b0;
    chk({tag, "_rdy3"}, IREADY, 0);
    chk({tag, "_dsel3"}, DSEL, exp_dsel);
    chk({tag, "_rin"}, RIN, exp_rin);
    chk({tag, "_done3"}, DONE, 1);
    chk({tag, "_zero"}, ZERO, exp_z);
    chk({tag, "_carry"}, CARRY, exp_c);
  endtask

  initial begin
    #12; chk_rst("reset");
    @(negedge CLK); RST = 1'b1;

    run("movi_r1", 3'd6, 3'd1, 3'd0, 3'd0, 16'h1234, 3'd1, 16'h1234, 0, 0, 0);
    @(negedge CLK); chk("r1_a", rf[1], 16'h1234);
    run("rd_r1",   3'd6, 3'd0, 3'd1, 3'd0, 16'h0000, 3'd0, 16'h1234, 0, 0, 0);
    chk("r1_b", rf[1], 16'h1234);
    run("movi_ff", 3'd6, 3'd1, 3'd0, 3'd0, 16'hFFFF, 3'd1, 16'hFFFF, 0, 0, 0);
    run("movi_01", 3'd6, 3'd2, 3'd0, 3'd0, 16'h0001, 3'd2, 16'h0001, 0, 0, 0);
    run("add_r3",  3'd1, 3'd3, 3'd1, 3'd2, 16'h0000, 3'd3, 16'h0000, 1, 1, 0);
    run("sub_r4",  3'd2, 3'd4, 3'd2, 3'd1, 16'h0000, 3'd4, 16'h0002, 0, 1, 0);
    run("and_r6",  3'd3, 3'd6, 3'd1, 3'd0, 16'h00AA, 3'd6, 16'h00AA, 0, 1, 0);
    run("or_r7",   3'd4, 3'd7, 3'd4, 3'd0, 16'h0100, 3'd7, 16'h0102, 0, 1, 0);
    run("movi_r5", 3'd6, 3'd5, 3'd0, 3'd0, 16'h0007, 3'd5, 16'h0007, 0, 1, 0);
    run("add_r5",  3'd1, 3'd5, 3'd5, 3'd5, 16'h0000, 3'd5, 16'h000E, 0, 0, 0);
    @(negedge CLK);
    chk("r3", rf[3], 16'h0000);
    chk("r4", rf[4], 16'h0002);
    chk("r5", rf[5], 16'h000E);
    chk("r7a", rf[7], 16'h0102);
    run("xor_d0",  3'd5, 3'd0, 3'd1, 3'd2, 16'h0000, 3'd0, 16'hFFFE, 0, 0, 0);
    run("nop",     3'd0, 3'd3, 3'd1, 3'd1, 16'h5555, 3'd0, 16'h0000, 0, 0, 0);
    run("xor_z",   3'd5, 3'd0, 3'd1, 3'd1, 16'h0000, 3'd0, 16'h0000, 1, 0, 0);
    @(negedge CLK);
    chk("r1_keep", rf[1], 16'hFFFF);
    chk("r2_keep", rf[2], 16'h0001);
    chk("r3_keep", rf[3], 16'h0000);

    // ADD R6 <- R1+R2, reset asserted during EXEC
    @(negedge CLK);
    OP = 3'd1; DREG = 3'd6; AREG = 3'd1; BREG = 3'd2; IMM = 16'h0; IVALID = 1'b1;
    @(posedge CLK); #1; IVALID = 1'b0;
    @(negedge CLK);
    chk("mid_read", IREADY, 0);
    @(negedge CLK);
    RST = 1'b0; #1;
    chk_rst("mid_rst");
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_done", DONE, 0);
      chk("post_irdy", IREADY, 1);
    end
    chk("r6_keep", rf[6], 16'h00AA);

    run("movi_8001", 3'd6, 3'd1, 3'd0, 3'd0, 16'h8001, 3'd1, 16'h8001, 0, 0, 0);
    run("shl1_r7",   3'd7, 3'd7, 3'd1, 3'd0, 16'h0000, 3'd7, 16'h0002, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("one_done", DONE, 0);
      chk("one_irdy", IREADY, 1);
    end
    chk("r7", rf[7], 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got %0d checks expected completion", checks);
    $fatal(1, "timeout");
  end
endmodule
